// File: rtl/hilo_muldiv_ctrl_pkg.sv
// rtl/hilo_muldiv_ctrl_pkg.sv - shared encodings and constants for the HI/LO multiply/divide sequencer
// Contents: op_code encodings, FSM state type, default data width, reset/write polarity constants.
package hilo_muldiv_ctrl_pkg;

    localparam int   DATA_W_DEF   = 32;
    localparam logic RST_ENABLE   = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter_core.sv
// rtl/hilo_muldiv_ctrl_div_iter_core.sv - unsigned restoring radix-2 divider, one quotient bit per cycle
// Ports: clk, rst_n (async active-low), start (load operands), abort (drop run),
//        dividend/divisor in, done (high in the cycle of the final iteration),
//        quotient/remainder (result of this cycle's iteration; final when done=1).
module div_iter_core
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int W    = 32,
    parameter int ITER = W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(ITER + 1);

    logic          run_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  rem_r;
    logic [W-1:0]  quo_r;
    logic [W-1:0]  dsr_r;
    logic [W:0]    shifted;
    logic [W:0]    trial;

    // quo_r doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter at the LSB.
    always_comb begin
        shifted = {rem_r, quo_r[W-1]};
        trial   = shifted - {1'b0, dsr_r};
        if (trial[W]) begin
            remainder = shifted[W-1:0];
            quotient  = {quo_r[W-2:0], 1'b0};
        end else begin
            remainder = trial[W-1:0];
            quotient  = {quo_r[W-2:0], 1'b1};
        end
    end

    assign done = run_r && (cnt_r == CW'(ITER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            run_r <= 1'b0;
            cnt_r <= '0;
            rem_r <= '0;
            quo_r <= '0;
            dsr_r <= '0;
        end else if (abort) begin
            run_r <= 1'b0;
        end else if (start) begin
            run_r <= 1'b1;
            cnt_r <= '0;
            rem_r <= '0;
            quo_r <= dividend;
            dsr_r <= divisor;
        end else if (run_r) begin
            rem_r <= remainder;
            quo_r <= quotient;
            cnt_r <= cnt_r + CW'(1);
            if (done) begin
                run_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - EX-stage sequencer for all HI/LO writes (MULT, DIV, MTHI/MTLO, optional MADD/MSUB)
// Ports: cpu_clk_50M, cpu_rst_n (async active-low); op_valid/op_code/src_a/src_b from EX decode;
//        flush aborts everything; hi_rd/lo_rd current HI/LO; stall_req (comb) to pipeline control;
//        busy while divider occupied; we/we_hi/we_lo + hi_o/lo_o write port to the HI/LO file.
// Build option: define HILO_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DIV_CYCLES = DATA_W
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              op_valid,
    input  logic [3:0]        op_code,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    input  logic [DATA_W-1:0] hi_rd,
    input  logic [DATA_W-1:0] lo_rd,
    output logic              stall_req,
    output logic              busy,
    output logic              we,
    output logic              we_hi,
    output logic              we_lo,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int PW = 2 * DATA_W;

    state_t            state;
    logic              we_r;
    logic              we_hi_r;
    logic              we_lo_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic              div_zero_r;
    logic [DATA_W-1:0] dvd_r;

    logic              is_div_op;
    logic              is_sdiv;
    logic              accept_div;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [PW-1:0]     prod_s;
    logic [PW-1:0]     prod_u;
    logic              core_done;
    logic [DATA_W-1:0] core_quo;
    logic [DATA_W-1:0] core_rem;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    assign is_div_op  = (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign is_sdiv    = (op_code == OP_DIV);
    assign accept_div = (state == ST_IDLE) && op_valid && !flush && is_div_op;

    // Signed products via sign extension to 2*DATA_W: the truncated unsigned
    // product of the extended operands equals the two's-complement product.
    assign prod_s = {{DATA_W{src_a[DATA_W-1]}}, src_a} * {{DATA_W{src_b[DATA_W-1]}}, src_b};
    assign prod_u = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};

    // The core divides magnitudes; -MIN stays MIN, which is correct as unsigned.
    assign mag_a = (is_sdiv && src_a[DATA_W-1]) ? -src_a : src_a;
    assign mag_b = (is_sdiv && src_b[DATA_W-1]) ? -src_b : src_b;

    assign quo_fix = neg_q_r ? -core_quo : core_quo;
    assign rem_fix = neg_r_r ? -core_rem : core_rem;

    div_iter_core #(
        .W    (DATA_W),
        .ITER (DIV_CYCLES)
    ) u_div_core (
        .clk       (cpu_clk_50M),
        .rst_n     (cpu_rst_n),
        .start     (accept_div),
        .abort     (flush),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (core_done),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

`ifdef HILO_MADD_EN
    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;
    logic [PW-1:0]     acc_src;

    // A write leaving this block this cycle has not reached hi_rd/lo_rd yet,
    // so forward it per half.
    assign acc_hi  = (we_r || we_hi_r) ? hi_o : hi_rd;
    assign acc_lo  = (we_r || we_lo_r) ? lo_o : lo_rd;
    assign acc_src = {acc_hi, acc_lo};
`else
    logic unused_madd;
    assign unused_madd = ^{hi_rd, lo_rd};
`endif

    assign busy      = (state != ST_IDLE);
    assign stall_req = (cpu_rst_n != RST_ENABLE) && !flush &&
                       (accept_div || (state == ST_DIV_RUN));

    // Flush cancels a write already staged in the output registers.
    assign we    = we_r    && !flush;
    assign we_hi = we_hi_r && !flush;
    assign we_lo = we_lo_r && !flush;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            state      <= ST_IDLE;
            we_r       <= 1'b0;
            we_hi_r    <= 1'b0;
            we_lo_r    <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
            dvd_r      <= '0;
        end else begin
            we_r    <= 1'b0;
            we_hi_r <= 1'b0;
            we_lo_r <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (op_valid) begin
                            case (op_code)
                                OP_MULT: begin
                                    we_r         <= WRITE_ENABLE;
                                    {hi_o, lo_o} <= prod_s;
                                end
                                OP_MULTU: begin
                                    we_r         <= WRITE_ENABLE;
                                    {hi_o, lo_o} <= prod_u;
                                end
                                OP_MTHI: begin
                                    we_hi_r <= WRITE_ENABLE;
                                    hi_o    <= src_a;
                                end
                                OP_MTLO: begin
                                    we_lo_r <= WRITE_ENABLE;
                                    lo_o    <= src_a;
                                end
                                OP_DIV, OP_DIVU: begin
                                    state      <= ST_DIV_RUN;
                                    neg_q_r    <= is_sdiv && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                                    neg_r_r    <= is_sdiv && src_a[DATA_W-1];
                                    div_zero_r <= (src_b == '0);
                                    dvd_r      <= src_a;
                                end
`ifdef HILO_MADD_EN
                                OP_MADD: begin
                                    we_r         <= WRITE_ENABLE;
                                    {hi_o, lo_o} <= acc_src + prod_s;
                                end
                                OP_MADDU: begin
                                    we_r         <= WRITE_ENABLE;
                                    {hi_o, lo_o} <= acc_src + prod_u;
                                end
                                OP_MSUB: begin
                                    we_r         <= WRITE_ENABLE;
                                    {hi_o, lo_o} <= acc_src - prod_s;
                                end
                                OP_MSUBU: begin
                                    we_r         <= WRITE_ENABLE;
                                    {hi_o, lo_o} <= acc_src - prod_u;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                    ST_DIV_RUN: begin
                        if (core_done) begin
                            state <= ST_DONE;
                            we_r  <= WRITE_ENABLE;
                            lo_o  <= div_zero_r ? '1 : quo_fix;
                            hi_o  <= div_zero_r ? dvd_r : rem_fix;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - self-checking bench for hilo_muldiv_ctrl (vector table, random model, corner sequences)
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    localparam int DW      = 32;
    localparam int DIV_CYC = 32;
    localparam int OBS     = 40;

    logic          clk;
    logic          rst_n;
    logic          op_valid;
    logic [3:0]    op_code;
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;
    logic          flush;
    logic [DW-1:0] hi_rd;
    logic [DW-1:0] lo_rd;
    logic          stall_req;
    logic          busy;
    logic          we;
    logic          we_hi;
    logic          we_lo;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    int n_cmp = 0;
    int n_err = 0;

    hilo_muldiv_ctrl #(.DATA_W(DW), .DIV_CYCLES(DIV_CYC)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .hi_rd       (hi_rd),
        .lo_rd       (lo_rd),
        .stall_req   (stall_req),
        .busy        (busy),
        .we          (we),
        .we_hi       (we_hi),
        .we_lo       (we_lo),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  exp_strb;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_stalls;
        int          exp_at;
    } vec_t;

    typedef struct {
        int          stalls;
        int          writes;
        int          multi;
        int          at;
        logic [2:0]  strb;
        logic [31:0] hi;
        logic [31:0] lo;
    } obs_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] s, input logic [31:0] h, input logic [31:0] l,
                                input int st, input int at);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_strb = s;
        v.exp_hi = h; v.exp_lo = l; v.exp_stalls = st; v.exp_at = at;
        return v;
    endfunction

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
    // the remainder follows the dividend sign, matching the required DIV rules.
    function automatic vec_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        vec_t        v;
        logic [63:0] p;
        longint      q;
        longint      r;
        v = mk(op, a, b, 3'b000, 32'd0, 32'd0, 0, 0);
        case (op)
            OP_MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                v.exp_strb = 3'b100; v.exp_hi = p[63:32]; v.exp_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                v.exp_strb = 3'b100; v.exp_hi = p[63:32]; v.exp_lo = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                v.exp_strb = 3'b100; v.exp_stalls = DIV_CYC + 1; v.exp_at = DIV_CYC;
                if (b == 32'd0) begin
                    v.exp_lo = 32'hFFFF_FFFF; v.exp_hi = a;
                end else if (op == OP_DIV) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    v.exp_lo = 32'(q); v.exp_hi = 32'(r);
                end else begin
                    v.exp_lo = a / b; v.exp_hi = a % b;
                end
            end
            OP_MTHI: begin v.exp_strb = 3'b010; v.exp_hi = a; end
            OP_MTLO: begin v.exp_strb = 3'b001; v.exp_lo = a; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic apply_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output obs_t r);
        r = '{default: 0};
        @(negedge clk);
        op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
        #1;
        if (stall_req) r.stalls++;
        @(negedge clk);
        op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
        for (int i = 0; i < OBS; i++) begin
            #1;
            if (stall_req) r.stalls++;
            if (we | we_hi | we_lo) begin
                r.writes++;
                if ((int'(we) + int'(we_hi) + int'(we_lo)) > 1) r.multi++;
                r.at = i; r.strb = {we, we_hi, we_lo}; r.hi = hi_o; r.lo = lo_o;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v, input obs_t r);
        chk({tag, " writes"}, 64'(r.writes), (v.exp_strb != 3'b000) ? 64'd1 : 64'd0);
        chk({tag, " stall_cycles"}, 64'(r.stalls), 64'(v.exp_stalls));
        chk({tag, " multi_strobe"}, 64'(r.multi), 64'd0);
        if (v.exp_strb != 3'b000 && r.writes == 1) begin
            chk({tag, " strobes"}, 64'(r.strb), 64'(v.exp_strb));
            chk({tag, " latency"}, 64'(r.at), 64'(v.exp_at));
            if (v.exp_strb[2] | v.exp_strb[1]) chk({tag, " hi_o"}, 64'(r.hi), 64'(v.exp_hi));
            if (v.exp_strb[2] | v.exp_strb[0]) chk({tag, " lo_o"}, 64'(r.lo), 64'(v.exp_lo));
        end
    endtask

    task automatic count_writes(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (we | we_hi | we_lo) n++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        obs_t        r;
        vec_t        v;
        int          n;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        rst_n = 1'b0; op_valid = 1'b0; op_code = 4'd0; src_a = '0; src_b = '0;
        flush = 1'b0; hi_rd = 32'h77; lo_rd = 32'h99;

        vecs.push_back(mk(OP_MULT,  32'hFFFF_FFFD, 32'd7,        3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0));
        vecs.push_back(mk(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0));
        vecs.push_back(mk(OP_MULT,  32'h8000_0000, 32'h8000_0000, 3'b100, 32'h4000_0000, 32'h0, 0, 0));
        vecs.push_back(mk(OP_DIVU,  32'd100,       32'd7,        3'b100, 32'd2,         32'd14,        33, 32));
        vecs.push_back(mk(OP_DIV,   32'hFFFF_FFF9, 32'd2,        3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 32));
        vecs.push_back(mk(OP_DIVU,  32'd5,         32'd0,        3'b100, 32'd5,         32'hFFFF_FFFF, 33, 32));
        vecs.push_back(mk(OP_DIV,   32'hFFFF_FFFB, 32'd0,        3'b100, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33, 32));
        vecs.push_back(mk(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 32'h0,        32'h8000_0000, 33, 32));
        vecs.push_back(mk(OP_DIV,   32'd7,         32'hFFFF_FFFE, 3'b100, 32'd1,         32'hFFFF_FFFD, 33, 32));
        vecs.push_back(mk(OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 3'b100, 32'hFFFF_FFFE, 32'd2,         33, 32));
        vecs.push_back(mk(OP_DIVU,  32'hFFFF_FFFF, 32'd1,        3'b100, 32'd0,         32'hFFFF_FFFF, 33, 32));
        vecs.push_back(mk(OP_MTHI,  32'hDEAD_BEEF, 32'd0,        3'b010, 32'hDEAD_BEEF, 32'd0, 0, 0));
        vecs.push_back(mk(OP_MTLO,  32'h0000_1234, 32'd0,        3'b001, 32'd0,         32'h1234, 0, 0));
`ifdef HILO_MADD_EN
        vecs.push_back(mk(OP_MSUB,  32'd1,         32'd2,        3'b100, 32'h77, 32'h97, 0, 0));
        vecs.push_back(mk(OP_MADD,  32'hFFFF_FFFF, 32'd1,        3'b100, 32'h77, 32'h98, 0, 0));
        vecs.push_back(mk(OP_MADDU, 32'hFFFF_FFFF, 32'd2,        3'b100, 32'h79, 32'h97, 0, 0));
        vecs.push_back(mk(OP_MSUBU, 32'd1,         32'h100,      3'b100, 32'h76, 32'hFFFF_FF99, 0, 0));
`else
        vecs.push_back(mk(OP_MADD,  32'd5, 32'd6, 3'b000, 32'd0, 32'd0, 0, 0));
        vecs.push_back(mk(OP_MADDU, 32'd5, 32'd6, 3'b000, 32'd0, 32'd0, 0, 0));
        vecs.push_back(mk(OP_MSUB,  32'd5, 32'd6, 3'b000, 32'd0, 32'd0, 0, 0));
        vecs.push_back(mk(OP_MSUBU, 32'd5, 32'd6, 3'b000, 32'd0, 32'd0, 0, 0));
`endif
        vecs.push_back(mk(4'hF,     32'd5, 32'd6, 3'b000, 32'd0, 32'd0, 0, 0));

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset strobes/busy/stall", 64'({we, we_hi, we_lo, busy, stall_req}), 64'd0);
        chk("reset hi_o/lo_o", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // vector table
        foreach (vecs[i]) begin
            apply_op(vecs[i].op, vecs[i].a, vecs[i].b, r);
            check_vec($sformatf("vec%0d", i), vecs[i], r);
        end

        // randomized against the reference model
        for (int i = 0; i < 120; i++) begin
            op = 4'($urandom_range(0, 5));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            v = model(op, a, b);
            apply_op(op, a, b, r);
            check_vec($sformatf("rnd%0d op%0d", i, op), v, r);
        end

        // DIV flushed at iteration 10, then MTLO
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        chk("flush: busy before flush", 64'(busy), 64'd1);
        flush = 1'b1;
        #1;
        chk("flush: stall_req in flush cycle", 64'(stall_req), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush: busy after flush", 64'(busy), 64'd0);
        count_writes(OBS, n);
        chk("flush: no write after abort", 64'(n), 64'd0);
        apply_op(OP_MTLO, 32'h1234, 32'd0, r);
        check_vec("mtlo after flush", mk(OP_MTLO, 32'h1234, 32'd0, 3'b001, 32'd0, 32'h1234, 0, 0), r);

        // MTHI then MTLO back-to-back
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MTHI; src_a = 32'hAAAA_0001;
        @(negedge clk);
        op_code = OP_MTLO; src_a = 32'h5555_0002;
        #1;
        chk("b2b first strobes", 64'({we, we_hi, we_lo}), 64'(3'b010));
        chk("b2b first hi_o", 64'(hi_o), 64'h0000_0000_AAAA_0001);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        chk("b2b second strobes", 64'({we, we_hi, we_lo}), 64'(3'b001));
        chk("b2b second lo_o", 64'(lo_o), 64'h0000_0000_5555_0002);

        // MULT write dropped by flush in the write cycle
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MULT; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b1;
        #1;
        chk("mult dropped by flush", 64'({we, we_hi, we_lo}), 64'd0);
        @(negedge clk);
        flush = 1'b0;

        // same-cycle flush and DIV: not accepted
        op_valid = 1'b1; op_code = OP_DIVU; src_a = 32'd9; src_b = 32'd2; flush = 1'b1;
        #1;
        chk("flush+op stall_req", 64'(stall_req), 64'd0);
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1;
        chk("flush+op busy", 64'(busy), 64'd0);
        count_writes(OBS, n);
        chk("flush+op no write", 64'(n), 64'd0);

        // op_valid ignored while dividing
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        op_valid = 1'b1; op_code = OP_MTHI; src_a = 32'hABCD;
        @(negedge clk);
        op_valid = 1'b0;
        r = '{default: 0};
        for (int i = 0; i < OBS; i++) begin
            #1;
            if (we | we_hi | we_lo) begin
                r.writes++; r.strb = {we, we_hi, we_lo}; r.hi = hi_o; r.lo = lo_o;
            end
            @(negedge clk);
        end
        chk("busy-ignore writes", 64'(r.writes), 64'd1);
        chk("busy-ignore strobes", 64'(r.strb), 64'(3'b100));
        chk("busy-ignore result", {r.hi, r.lo}, {32'd2, 32'd14});

        // async reset mid-divide
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_DIVU; src_a = 32'd77; src_b = 32'd5;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("pre-reset busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-div reset flags", 64'({we, we_hi, we_lo, busy, stall_req}), 64'd0);
        chk("mid-div reset data", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_writes(OBS, n);
        chk("mid-div reset no write", 64'(n), 64'd0);

`ifdef HILO_MADD_EN
        // MULTU then MADDU: accumulate must use the in-flight write
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MULTU; src_a = 32'd2; src_b = 32'd3;
        @(negedge clk);
        op_code = OP_MADDU; src_a = 32'd4; src_b = 32'd5;
        #1;
        chk("fwd first write", {31'd0, we, hi_o, lo_o} , {31'd0, 1'b1, 32'd0, 32'd6});
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        chk("fwd madd write", {31'd0, we, hi_o, lo_o}, {31'd0, 1'b1, 32'd0, 32'd26});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
